// File: rtl/stone_pkg.sv
// Stone-record layout, type codes, default colours and screen geometry shared by the
// rope controller and the stone drawer.
package stone_pkg;

    localparam int unsigned X_MSB    = 31;
    localparam int unsigned X_LSB    = 23;
    localparam int unsigned Y_MSB    = 18;
    localparam int unsigned Y_LSB    = 11;
    localparam int unsigned TYPE_MSB = 3;
    localparam int unsigned TYPE_LSB = 2;
    localparam int unsigned VIS      = 1;
    localparam int unsigned MOV      = 0;

    localparam logic [1:0] TYPE_STONE   = 2'b00;
    localparam logic [1:0] TYPE_GOLD    = 2'b01;
    localparam logic [1:0] TYPE_DIAMOND = 2'b10;

    localparam logic [2:0] DEF_COLOUR_STONE   = 3'b111;
    localparam logic [2:0] DEF_COLOUR_GOLD    = 3'b110;
    localparam logic [2:0] DEF_COLOUR_DIAMOND = 3'b011;

    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWait,
        StLatch,
        StDraw,
        StDone
    } draw_state_e;

endpackage

// File: rtl/stone_pixel_scanner.sv
// Raster dx/dy counter over one square sprite; exposes the offset the next step lands on
// so the caller can register pixel coordinates a cycle ahead.
module stone_pixel_scanner #(
    parameter int unsigned SPRITE_SIZE = 16,
    localparam int unsigned OFF_W = $clog2(SPRITE_SIZE)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             step,
    output logic [OFF_W-1:0] nx,
    output logic [OFF_W-1:0] ny,
    output logic             last
);

    localparam logic [OFF_W-1:0] MAX = OFF_W'(SPRITE_SIZE - 1);

    logic [OFF_W-1:0] dx_q;
    logic [OFF_W-1:0] dy_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (clear) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (step) begin
            dx_q <= nx;
            dy_q <= ny;
        end
    end

    // Power-of-two size lets dx wrap naturally at the row end.
    assign nx   = dx_q + OFF_W'(1);
    assign ny   = (dx_q == MAX) ? dy_q + OFF_W'(1) : dy_q;
    assign last = (dx_q == MAX) && (dy_q == MAX);

endmodule

// File: rtl/stone_drawer.sv
// Walks the stone RAM once per frame request and paints each visible record as a solid
// square sprite into the pixel stream, clipping against the screen edge.
module stone_drawer #(
    parameter int unsigned SPRITE_SIZE = 16,
    parameter int unsigned SCREEN_W = stone_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = stone_pkg::SCREEN_H,
    parameter int unsigned COLOUR_W = 3,
    parameter logic [COLOUR_W-1:0] COLOUR_STONE   = COLOUR_W'(stone_pkg::DEF_COLOUR_STONE),
    parameter logic [COLOUR_W-1:0] COLOUR_GOLD    = COLOUR_W'(stone_pkg::DEF_COLOUR_GOLD),
    parameter logic [COLOUR_W-1:0] COLOUR_DIAMOND = COLOUR_W'(stone_pkg::DEF_COLOUR_DIAMOND)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [3:0]          quantity,
    input  logic [31:0]         data,
    output logic                draw_stone_flag,
    output logic [3:0]          draw_index,
    output logic [8:0]          x,
    output logic [7:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    import stone_pkg::*;

    localparam int unsigned OFF_W = $clog2(SPRITE_SIZE);

    draw_state_e state_q, state_d;
    logic [3:0] q_lat_q, q_lat_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] idx_inc;
    logic       rec_last;
    logic [8:0] x_base_q;
    logic [7:0] y_base_q;

    logic             scan_clear;
    logic             scan_step;
    logic [OFF_W-1:0] nx;
    logic [OFF_W-1:0] ny;
    logic             last;

    logic                load_px;
    logic [8:0]          base_x;
    logic [7:0]          base_y;
    logic [OFF_W-1:0]    off_x;
    logic [OFF_W-1:0]    off_y;
    logic [9:0]          sum_x;
    logic [8:0]          sum_y;
    logic [COLOUR_W-1:0] type_colour;

    logic unused_data;
    assign unused_data = ^{data[22:19], data[10:4], data[MOV]};

    stone_pixel_scanner #(
        .SPRITE_SIZE(SPRITE_SIZE)
    ) u_scanner (
        .clock (clock),
        .resetn(resetn),
        .clear (scan_clear),
        .step  (scan_step),
        .nx    (nx),
        .ny    (ny),
        .last  (last)
    );

    assign idx_inc  = idx_q + 4'd1;
    assign rec_last = (idx_inc == q_lat_q);

    always_comb begin
        state_d    = state_q;
        q_lat_d    = q_lat_q;
        idx_d      = idx_q;
        scan_clear = 1'b0;
        scan_step  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    q_lat_d = quantity;
                    idx_d   = '0;
                    state_d = (quantity == 4'd0) ? StDone : StAddr;
                end
            end
            StAddr:  state_d = StWait;
            StWait:  state_d = StLatch;
            StLatch: begin
                scan_clear = 1'b1;
                if (data[VIS]) begin
                    state_d = StDraw;
                end else begin
                    idx_d   = idx_inc;
                    state_d = rec_last ? StDone : StAddr;
                end
            end
            StDraw: begin
                scan_step = 1'b1;
                if (last) begin
                    idx_d   = idx_inc;
                    state_d = rec_last ? StDone : StAddr;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            q_lat_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            q_lat_q <= q_lat_d;
            idx_q   <= idx_d;
        end
    end

    // The pixel shown in a DRAW cycle is registered one cycle earlier: pixel 0 from the
    // record itself in LATCH, later pixels from the scanner's look-ahead offset.
    always_comb begin
        load_px = 1'b0;
        base_x  = x_base_q;
        base_y  = y_base_q;
        off_x   = nx;
        off_y   = ny;
        if (state_q == StLatch) begin
            load_px = data[VIS];
            base_x  = data[X_MSB:X_LSB];
            base_y  = data[Y_MSB:Y_LSB];
            off_x   = '0;
            off_y   = '0;
        end else if (state_q == StDraw) begin
            load_px = !last;
        end
    end

    assign sum_x = {1'b0, base_x} + 10'(off_x);
    assign sum_y = {1'b0, base_y} + 9'(off_y);

    always_comb begin
        case (data[TYPE_MSB:TYPE_LSB])
            TYPE_STONE: type_colour = COLOUR_STONE;
            TYPE_GOLD:  type_colour = COLOUR_GOLD;
            default:    type_colour = COLOUR_DIAMOND;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_base_q <= '0;
            y_base_q <= '0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
        end else begin
            plot <= 1'b0;
            if (state_q == StLatch) begin
                x_base_q <= data[X_MSB:X_LSB];
                y_base_q <= data[Y_MSB:Y_LSB];
            end
            if (load_px) begin
                x    <= sum_x[8:0];
                y    <= sum_y[7:0];
                plot <= (sum_x < 10'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));
                if (state_q == StLatch) begin
                    colour <= type_colour;
                end
            end
        end
    end

    assign busy            = (state_q != StIdle);
    assign draw_stone_flag = busy;
    assign done            = (state_q == StDone);
    assign draw_index      = busy ? idx_q : 4'd0;

endmodule

// File: tb/tb_stone_drawer.sv
// Randomized and directed frames for stone_drawer, checked against a per-record cycle and
// pixel list derived from the record contents.
module tb_stone_drawer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  quantity = 4'd0;
    logic [31:0] data = 32'd0;
    logic        draw_stone_flag;
    logic [3:0]  draw_index;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [16];

    typedef struct {
        int cyc;
        int px;
        int py;
        int col;
    } pix_t;

    pix_t exp_px[$];
    int   exp_addr[$];
    int   exp_done;

    always #5 clock = ~clock;

    always @(posedge clock) data <= mem[draw_index];

    stone_drawer dut (
        .clock          (clock),
        .resetn         (resetn),
        .start          (start),
        .quantity       (quantity),
        .data           (data),
        .draw_stone_flag(draw_stone_flag),
        .draw_index     (draw_index),
        .x              (x),
        .y              (y),
        .colour         (colour),
        .plot           (plot),
        .busy           (busy),
        .done           (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rec(input logic [8:0] rx, input logic [7:0] ry,
                                        input logic [1:0] t, input logic v, input logic m);
        logic [31:0] r;
        r = $urandom;
        r[31:23] = rx;
        r[18:11] = ry;
        r[3:2]   = t;
        r[1]     = v;
        r[0]     = m;
        return r;
    endfunction

    function automatic int colour_of(input logic [1:0] t);
        if (t == 2'b00) return 7;
        if (t == 2'b01) return 6;
        return 3;
    endfunction

    // Each record starts with 3 cycles of address/wait/latch; a visible one then spends
    // 256 cycles on its pixels in raster order.
    task automatic build_model(input int q);
        int cyc_rec;
        cyc_rec = 1;
        exp_px.delete();
        exp_addr.delete();
        for (int i = 0; i < q; i++) begin
            logic [31:0] r;
            r = mem[i];
            exp_addr.push_back(cyc_rec);
            if (r[1]) begin
                for (int k = 0; k < 256; k++) begin
                    int px;
                    int py;
                    px = int'(r[31:23]) + k % 16;
                    py = int'(r[18:11]) + k / 16;
                    if (px < 320 && py < 240)
                        exp_px.push_back('{cyc_rec + 3 + k, px, py, colour_of(r[3:2])});
                end
                cyc_rec += 259;
            end else begin
                cyc_rec += 3;
            end
        end
        exp_done = cyc_rec;
    endtask

    task automatic run_frame(input int q, input bit disturb, input string name);
        int   cyc;
        int   done_cyc;
        int   flag_cnt;
        int   busy_cnt;
        int   done_cnt;
        int   plots;
        int   ai;
        int   n_exp;
        pix_t p;
        logic [63:0] expv;
        done_cyc = -1;
        flag_cnt = 0;
        busy_cnt = 0;
        done_cnt = 0;
        plots    = 0;
        ai       = 0;
        build_model(q);
        n_exp = exp_px.size();
        @(negedge clock);
        start    = 1'b1;
        quantity = 4'(q);
        @(negedge clock);
        start = 1'b0;
        cyc   = 1;
        forever begin
            if (draw_stone_flag) flag_cnt++;
            if (busy) busy_cnt++;
            if (plot) begin
                plots++;
                if (exp_px.size() > 0) begin
                    p    = exp_px.pop_front();
                    expv = {16'(p.cyc), 16'(p.px), 16'(p.py), 16'(p.col)};
                end else begin
                    expv = '1;
                end
                check_eq({name, " pixel"}, {16'(cyc), 16'(x), 16'(y), 16'(colour)}, expv);
            end
            if (ai < exp_addr.size() && cyc == exp_addr[ai]) begin
                check_eq({name, " index"}, 64'(draw_index), 64'(ai));
                ai++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            start = 1'b0;
            if (disturb && cyc == 40) begin
                start    = 1'b1;
                quantity = 4'(q) ^ 4'd5;
            end
            if (done_cyc >= 0 || cyc > exp_done + 20) break;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        check_eq({name, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check_eq({name, " plot_count"}, 64'(plots), 64'(n_exp));
        check_eq({name, " flag_cycles"}, 64'(flag_cnt), 64'(exp_done));
        check_eq({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_done));
        check_eq({name, " done_pulses"}, 64'(done_cnt), 64'd1);
        @(negedge clock);
        check_eq({name, " idle_after"}, {61'd0, draw_stone_flag, busy, plot}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = rec(9'(i * 7), 8'(i * 3), 2'b00, 1'b0, 1'b0);

        #3;
        check_eq("reset outputs",
                 {38'd0, draw_stone_flag, draw_index, x, y, colour, plot, busy, done}, 64'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Empty frame: single DONE cycle.
        run_frame(0, 1'b0, "empty");

        // Visible gold then invisible record, with a stray start and quantity change mid-sprite.
        mem[0] = rec(9'd100, 8'd50, 2'b01, 1'b1, 1'b0);
        mem[1] = rec(9'd200, 8'd10, 2'b00, 1'b0, 1'b0);
        run_frame(2, 1'b1, "gold");

        // Sprite overlapping the bottom-right corner.
        mem[0] = rec(9'd310, 8'd230, 2'b00, 1'b1, 1'b0);
        run_frame(1, 1'b0, "clip");

        // Type 11 with the moving bit set.
        mem[0] = rec(9'd5, 8'd7, 2'b11, 1'b1, 1'b1);
        mem[1] = rec(9'd40, 8'd40, 2'b10, 1'b0, 1'b1);
        run_frame(2, 1'b0, "diamond");

        // Reset in the middle of a sprite.
        mem[0] = rec(9'd20, 8'd20, 2'b00, 1'b1, 1'b0);
        @(negedge clock);
        start    = 1'b1;
        quantity = 4'd1;
        @(negedge clock);
        start = 1'b0;
        repeat (100) @(negedge clock);
        check_eq("pre-reset plot", 64'(plot), 64'd1);
        #2 resetn = 1'b0;
        #1 check_eq("async reset", {59'd0, plot, busy, draw_stone_flag, done, |colour}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_eq("held reset done", {62'd0, done, busy}, 64'd0);
        end
        resetn = 1'b1;
        mem[0] = rec(9'd60, 8'd100, 2'b01, 1'b1, 1'b0);
        run_frame(1, 1'b0, "after reset");

        // Random frames; records beyond quantity are live junk that must not be drawn.
        for (int f = 0; f < 6; f++) begin
            int q;
            for (int i = 0; i < 16; i++) begin
                logic [8:0] rx;
                logic [7:0] ry;
                rx = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(290, 330))
                                                 : 9'($urandom_range(0, 511));
                ry = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(215, 255))
                                                 : 8'($urandom_range(0, 255));
                mem[i] = rec(rx, ry, 2'($urandom_range(0, 3)),
                             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            end
            q = $urandom_range(0, 15);
            run_frame(q, 1'($urandom_range(0, 1)), $sformatf("random%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
